// File: rtl/multi_centroid_engine.sv
// multi_centroid_engine
//   Per-frame centroid engine for NUM_CH independent pixel masks. While pixels
//   stream in, it accumulates x/y sums and pixel counts for each channel. On a
//   frame-end pulse it snapshots those totals. A single shared restoring divider
//   then computes the floor-mean x and y for each channel in turn, and the engine
//   emits one record per channel over a valid/ready stream.
//
//   Optional feature macro: CENTROID_BBOX_EN
//     defined   -> per-channel bounding box {xmin,xmax,ymin,ymax} tracked and emitted
//     undefined -> no bbox registers, bbox_out tied to 0
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-high reset
//   x_in, y_in, mask_in       pixel coordinate and per-channel membership
//   valid_in                  pixel strobe
//   tabulate_in               frame-end pulse (snapshot + start computation)
//   ch_out .. bbox_out        record fields (channel, mean x/y, count, found, bbox)
//   valid_out / ready_in      record handshake; fields hold until accepted
//   busy_out                  snapshot taken, records not yet all accepted
//   overrun_out               one-cycle pulse: tabulate_in arrived while busy
module multi_centroid_engine #(
   parameter int HRES      = 320,
   parameter int VRES      = 180,
   parameter int NUM_CH    = 2,
   parameter int MIN_COUNT = 1,
   localparam int HW       = $clog2(HRES),
   localparam int VW       = $clog2(VRES),
   localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CW       = HW + VW
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [HW-1:0]         x_in,
   input  logic [VW-1:0]         y_in,
   input  logic [NUM_CH-1:0]     mask_in,
   input  logic                  valid_in,
   input  logic                  tabulate_in,
   output logic [CHW-1:0]        ch_out,
   output logic [HW-1:0]         x_out,
   output logic [VW-1:0]         y_out,
   output logic [CW-1:0]         count_out,
   output logic                  found_out,
   output logic [2*HW+2*VW-1:0]  bbox_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy_out,
   output logic                  overrun_out
);
   localparam int XSW = CW + HW;
   localparam int YSW = CW + VW;
   localparam int DW  = (XSW > YSW) ? XSW : YSW;
   localparam int DCW = $clog2(DW);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV_X, S_DIV_Y, S_EMIT} state_t;
   state_t state;

   logic [XSW-1:0] snap_sx  [NUM_CH];
   logic [YSW-1:0] snap_sy  [NUM_CH];
   logic [CW-1:0]  snap_cnt [NUM_CH];
`ifdef CENTROID_BBOX_EN
   logic [HW-1:0]  snap_xmin [NUM_CH];
   logic [HW-1:0]  snap_xmax [NUM_CH];
   logic [VW-1:0]  snap_ymin [NUM_CH];
   logic [VW-1:0]  snap_ymax [NUM_CH];
`endif

   // Per-channel live accumulators and their frame snapshots. On tabulate the
   // "next" value, which already contains a same-cycle pixel, goes to the
   // snapshot while the live registers restart from empty.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic           hit;
      logic [XSW-1:0] sx, sx_next, ssx;
      logic [YSW-1:0] sy, sy_next, ssy;
      logic [CW-1:0]  cnt, cnt_next, scnt;

      assign hit      = valid_in & mask_in[gi];
      assign sx_next  = sx + (hit ? XSW'(x_in) : '0);
      assign sy_next  = sy + (hit ? YSW'(y_in) : '0);
      assign cnt_next = cnt + CW'(hit);

      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            sx <= '0; sy <= '0; cnt <= '0;
            ssx <= '0; ssy <= '0; scnt <= '0;
         end else if (tabulate_in) begin
            sx <= '0; sy <= '0; cnt <= '0;
            // A frame ending while busy is dropped: the snapshot is left alone.
            if (!busy_out) begin
               ssx <= sx_next; ssy <= sy_next; scnt <= cnt_next;
            end
         end else begin
            sx <= sx_next; sy <= sy_next; cnt <= cnt_next;
         end
      end

      assign snap_sx[gi]  = ssx;
      assign snap_sy[gi]  = ssy;
      assign snap_cnt[gi] = scnt;

`ifdef CENTROID_BBOX_EN
      logic [HW-1:0] xmin, xmax, xmin_next, xmax_next, sxmin, sxmax;
      logic [VW-1:0] ymin, ymax, ymin_next, ymax_next, symin, symax;

      assign xmin_next = (hit && x_in < xmin) ? x_in : xmin;
      assign xmax_next = (hit && x_in > xmax) ? x_in : xmax;
      assign ymin_next = (hit && y_in < ymin) ? y_in : ymin;
      assign ymax_next = (hit && y_in > ymax) ? y_in : ymax;

      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
            sxmin <= '0; sxmax <= '0; symin <= '0; symax <= '0;
         end else if (tabulate_in) begin
            xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
            if (!busy_out) begin
               sxmin <= xmin_next; sxmax <= xmax_next;
               symin <= ymin_next; symax <= ymax_next;
            end
         end else begin
            xmin <= xmin_next; xmax <= xmax_next;
            ymin <= ymin_next; ymax <= ymax_next;
         end
      end

      assign snap_xmin[gi] = sxmin;
      assign snap_xmax[gi] = sxmax;
      assign snap_ymin[gi] = symin;
      assign snap_ymax[gi] = symax;
`endif
   end

   // Shared restoring divider: quo holds the not-yet-consumed dividend bits in
   // its top and collects quotient bits at its bottom. The remainder is always
   // below the divisor (a count), so CW bits are enough to hold it.
   logic [CHW-1:0] cur_ch;
   logic [DCW-1:0] bit_cnt;
   logic [CW-1:0]  rem, rem_next;
   logic [DW-1:0]  quo, quo_next;
   logic [CW:0]    trial;
   logic           ge;
   logic [XSW-1:0] sel_sx;
   logic [YSW-1:0] sel_sy;
   logic [CW-1:0]  sel_cnt;
   logic           cnt_ok;

   assign sel_sx  = snap_sx[cur_ch];
   assign sel_sy  = snap_sy[cur_ch];
   assign sel_cnt = snap_cnt[cur_ch];
   assign cnt_ok  = (sel_cnt != '0) && (int'(sel_cnt) >= MIN_COUNT);

   always_comb begin
      trial    = {rem, quo[DW-1]};
      ge       = (trial >= {1'b0, sel_cnt});
      rem_next = ge ? CW'(trial - {1'b0, sel_cnt}) : trial[CW-1:0];
      quo_next = {quo[DW-2:0], ge};
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= S_IDLE;
         cur_ch      <= '0;
         bit_cnt     <= '0;
         rem         <= '0;
         quo         <= '0;
         ch_out      <= '0;
         x_out       <= '0;
         y_out       <= '0;
         count_out   <= '0;
         found_out   <= 1'b0;
         valid_out   <= 1'b0;
         busy_out    <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         overrun_out <= tabulate_in && busy_out;
         case (state)
            S_IDLE: begin
               if (tabulate_in) begin
                  state    <= S_LOAD;
                  cur_ch   <= '0;
                  busy_out <= 1'b1;
               end
            end
            S_LOAD: begin
               ch_out    <= cur_ch;
               count_out <= sel_cnt;
               found_out <= cnt_ok;
               if (cnt_ok) begin
                  rem     <= '0;
                  quo     <= DW'(sel_sx);
                  bit_cnt <= '0;
                  state   <= S_DIV_X;
               end else begin
                  x_out     <= '0;
                  y_out     <= '0;
                  valid_out <= 1'b1;
                  state     <= S_EMIT;
               end
            end
            S_DIV_X: begin
               if (bit_cnt == DCW'(DW - 1)) begin
                  x_out   <= quo_next[HW-1:0];
                  rem     <= '0;
                  quo     <= DW'(sel_sy);
                  bit_cnt <= '0;
                  state   <= S_DIV_Y;
               end else begin
                  rem     <= rem_next;
                  quo     <= quo_next;
                  bit_cnt <= bit_cnt + DCW'(1);
               end
            end
            S_DIV_Y: begin
               if (bit_cnt == DCW'(DW - 1)) begin
                  y_out     <= quo_next[VW-1:0];
                  valid_out <= 1'b1;
                  state     <= S_EMIT;
               end else begin
                  rem     <= rem_next;
                  quo     <= quo_next;
                  bit_cnt <= bit_cnt + DCW'(1);
               end
            end
            S_EMIT: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  if (cur_ch == CHW'(NUM_CH - 1)) begin
                     state    <= S_IDLE;
                     busy_out <= 1'b0;
                  end else begin
                     cur_ch <= cur_ch + CHW'(1);
                     state  <= S_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CENTROID_BBOX_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bbox_out <= '0;
      end else if (state == S_LOAD) begin
         bbox_out <= cnt_ok ? {snap_xmin[cur_ch], snap_xmax[cur_ch],
                               snap_ymin[cur_ch], snap_ymax[cur_ch]} : '0;
      end
   end
`else
   assign bbox_out = '0;
`endif

endmodule

// File: tb/tb_multi_centroid_engine.sv
// Bench for multi_centroid_engine: a scoreboard of expected records is
// filled when a frame is tabulated and drained as records are accepted.
`timescale 1ns/1ps
module tb_multi_centroid_engine;
   localparam int HRES = 320, VRES = 180, NUM_CH = 2, MIN_COUNT = 1;
   localparam int HW  = $clog2(HRES);
   localparam int VW  = $clog2(VRES);
   localparam int CHW = 1;
   localparam int CW  = HW + VW;
   localparam int DW  = (CW + HW > CW + VW) ? CW + HW : CW + VW;
   localparam int BBW = 2 * HW + 2 * VW;

   logic              clk_in = 0, rst_in = 1;
   logic [HW-1:0]     x_in = '0;
   logic [VW-1:0]     y_in = '0;
   logic [NUM_CH-1:0] mask_in = '0;
   logic              valid_in = 0, tabulate_in = 0, ready_in = 1;
   logic [CHW-1:0]    ch_out;
   logic [HW-1:0]     x_out;
   logic [VW-1:0]     y_out;
   logic [CW-1:0]     count_out;
   logic              found_out, valid_out, busy_out, overrun_out;
   logic [BBW-1:0]    bbox_out;

   always #5 clk_in = ~clk_in;

   multi_centroid_engine #(.HRES(HRES), .VRES(VRES), .NUM_CH(NUM_CH), .MIN_COUNT(MIN_COUNT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
      .valid_in(valid_in), .tabulate_in(tabulate_in), .ch_out(ch_out), .x_out(x_out),
      .y_out(y_out), .count_out(count_out), .found_out(found_out), .bbox_out(bbox_out),
      .valid_out(valid_out), .ready_in(ready_in), .busy_out(busy_out), .overrun_out(overrun_out)
   );

   typedef struct {
      int ch; int x; int y; int cnt; bit found; logic [BBW-1:0] bbox;
   } rec_t;

   rec_t exp_q[$];
   int   total = 0, bad = 0;
   bit   exp_busy = 0;
   int   m_sx[NUM_CH], m_sy[NUM_CH], m_cnt[NUM_CH];
   int   m_xmin[NUM_CH], m_xmax[NUM_CH], m_ymin[NUM_CH], m_ymax[NUM_CH];

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void clear_model();
      for (int c = 0; c < NUM_CH; c++) begin
         m_sx[c] = 0; m_sy[c] = 0; m_cnt[c] = 0;
         m_xmin[c] = (1 << HW) - 1; m_xmax[c] = 0;
         m_ymin[c] = (1 << VW) - 1; m_ymax[c] = 0;
      end
   endfunction

   function automatic void push_frame();
      for (int c = 0; c < NUM_CH; c++) begin
         rec_t r;
         r.ch    = c;
         r.cnt   = m_cnt[c];
         r.found = (m_cnt[c] >= MIN_COUNT) && (m_cnt[c] != 0);
         r.x     = r.found ? m_sx[c] / m_cnt[c] : 0;
         r.y     = r.found ? m_sy[c] / m_cnt[c] : 0;
         r.bbox  = '0;
`ifdef CENTROID_BBOX_EN
         if (r.found)
            r.bbox = {HW'(m_xmin[c]), HW'(m_xmax[c]), VW'(m_ymin[c]), VW'(m_ymax[c])};
`endif
         exp_q.push_back(r);
      end
   endfunction

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic drive(int x, int y, logic [NUM_CH-1:0] m, bit v, bit tab);
      x_in = HW'(x); y_in = VW'(y); mask_in = m; valid_in = v; tabulate_in = tab;
      if (v) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
               m_sx[c] += x; m_sy[c] += y; m_cnt[c] += 1;
               if (x < m_xmin[c]) m_xmin[c] = x;
               if (x > m_xmax[c]) m_xmax[c] = x;
               if (y < m_ymin[c]) m_ymin[c] = y;
               if (y > m_ymax[c]) m_ymax[c] = y;
            end
         end
      end
      if (tab) begin
         if (!exp_busy) begin
            push_frame();
            exp_busy = 1;
         end
         clear_model();
      end
      @(posedge clk_in); #1;
      valid_in = 0; tabulate_in = 0; mask_in = '0;
   endtask

   task automatic wait_idle(string tag);
      int n = 0;
      while ((busy_out || exp_q.size() != 0) && n < 3000) begin
         @(posedge clk_in); #1; n++;
      end
      check({tag, "_idle_timeout"}, 64'(n >= 3000), 0);
   endtask

   // Latency counted so that the tabulate sampling edge is cycle 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_out && lat < 500) begin
         @(posedge clk_in); #1; lat++;
      end
   endtask

   // Scoreboard drain: a record is consumed on each accepting edge.
   always @(negedge clk_in) begin
      if (!rst_in && valid_out && ready_in) begin
         rec_t e;
         $display("rec ch=%0d x=%0d y=%0d count=%0d found=%0d bbox=%h",
                  ch_out, x_out, y_out, count_out, found_out, bbox_out);
         check("rec_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ch", ch_out, e.ch);
            check("x", x_out, e.x);
            check("y", y_out, e.y);
            check("count", count_out, e.cnt);
            check("found", found_out, e.found);
            check("bbox", bbox_out, e.bbox);
            if (e.ch == NUM_CH - 1) exp_busy = 0;
         end
      end
   end

   initial begin
      int lat;
      bit changed;
      logic [63:0] snap;
      clear_model();
      repeat (3) @(posedge clk_in);
      #1 rst_in = 0;
      check("rst_valid", valid_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_count", count_out, 0);
      check("rst_x", x_out, 0);
      check("rst_overrun", overrun_out, 0);
      drive(0, 0, 2'b00, 0, 0);

      // Basic frame: ch0 mean (20,30), ch1 empty; found-channel latency.
      drive(10, 20, 2'b01, 1, 0);
      drive(30, 40, 2'b01, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      check("busy_after_tab", busy_out, 1);
      check("no_overrun", overrun_out, 0);
      wait_valid(lat);
      check("lat_found", lat, 2 * DW + 2);
      wait_idle("basic");

      // Floor division, ch1 also populated.
      drive(0, 0, 2'b01, 1, 0);
      drive(1, 0, 2'b01, 1, 0);
      drive(1, 1, 2'b01, 1, 0);
      drive(2, 3, 2'b10, 1, 0);
      drive(5, 8, 2'b10, 1, 0);
      drive(9, 9, 2'b10, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      wait_idle("floor");

      // Only pixel arrives in the tabulate cycle, at the frame corner.
      drive(319, 179, 2'b11, 1, 1);
      wait_idle("same_cycle");

      // Empty frame: both channels skip the divider.
      drive(0, 0, 2'b00, 0, 1);
      wait_valid(lat);
      check("lat_empty", lat, 2);
      wait_idle("empty");

      // Back-pressure on ch0 while the next frame is fed.
      drive(100, 50, 2'b11, 1, 0);
      drive(200, 150, 2'b01, 1, 0);
      ready_in = 0;
      drive(0, 0, 2'b00, 0, 1);
      wait_valid(lat);
      check("stall_valid_seen", valid_out, 1);
      snap = {ch_out, x_out, y_out, count_out, found_out, bbox_out[19:0]};
      changed = 0;
      for (int i = 0; i < 50; i++) begin
         drive(i * 3, i, (i % 3 == 0) ? 2'b01 : 2'b10, i < 20, 0);
         if ({ch_out, x_out, y_out, count_out, found_out, bbox_out[19:0]} !== snap ||
             valid_out !== 1'b1)
            changed = 1;
      end
      check("stall_stable", changed, 0);
      ready_in = 1;
      wait_idle("stall");
      drive(0, 0, 2'b00, 0, 1);
      wait_idle("after_stall");

      // Overrun: second tabulate while busy drops its frame.
      drive(5, 5, 2'b01, 1, 0);
      drive(7, 9, 2'b01, 1, 0);
      drive(100, 100, 2'b10, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      drive(300, 170, 2'b11, 1, 0);
      drive(250, 120, 2'b11, 1, 0);
      drive(1, 1, 2'b11, 1, 1);
      check("overrun_pulse", overrun_out, 1);
      drive(0, 0, 2'b00, 0, 0);
      check("overrun_single", overrun_out, 0);
      wait_idle("overrun");
      drive(50, 60, 2'b01, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      wait_idle("post_overrun");

      // Random frames.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 30; i++)
            drive($urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1),
                  NUM_CH'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 0);
         drive(0, 0, 2'b00, 0, 1);
         wait_idle("random");
      end

      // Asynchronous reset in the middle of the x division.
      drive(10, 10, 2'b01, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      repeat (8) drive(0, 0, 2'b00, 0, 0);
      check("pre_rst_busy", busy_out, 1);
      check("pre_rst_count", count_out, 1);
      rst_in = 1;
      #2;
      check("mid_rst_valid", valid_out, 0);
      check("mid_rst_busy", busy_out, 0);
      check("mid_rst_count", count_out, 0);
      check("mid_rst_found", found_out, 0);
      check("mid_rst_ch", ch_out, 0);
      exp_q.delete();
      exp_busy = 0;
      clear_model();
      @(posedge clk_in); #1 rst_in = 0;
      drive(0, 0, 2'b00, 0, 0);
      drive(200, 100, 2'b10, 1, 0);
      drive(0, 0, 2'b00, 0, 1);
      wait_idle("post_reset");

      check("queue_empty", exp_q.size(), 0);
      check("final_busy", busy_out, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
